part2_dot_mac: RTL and testbench

//  Parametrised pipelined signed multiply-accumulate (dot-product) engine.

---
 rtl/part2_dot_mac.sv | 186 ++++++++++++++++++
 tb/tb_part2_dot_mac.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/part2_dot_mac.sv
`default_nettype none
// ============================================================================
//  Module   : part2_dot_mac
//  Purpose  : Pipelined signed multiply-accumulate (dot-product) engine.
//             Accumulates VEC_LEN signed products of (a,b), emits the sum on
//             f with a one-cycle valid_out pulse, then starts a new vector.
//  Options  : MAC_SAT_EN - clamp the running sum to the ACC_W signed range
//             and report clamping on sat; undefined means the sum wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module part2_dot_mac #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 20,
    parameter int VEC_LEN   = 4,
    parameter int PIPE_MULT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             clear,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] f,
    output logic             valid_out,
    output logic             sat
);

    // Element counter needs at least one bit even for single-element vectors.
    localparam int               c_cnt_w    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(VEC_LEN - 1);

    // Stage 1: operand registers
    logic signed [IN_W-1:0]   a_q;
    logic signed [IN_W-1:0]   b_q;
    logic                     v1_q;

    // Full-precision product and the product/valid seen by the accumulator
    logic signed [2*IN_W-1:0] mult;
    logic signed [2*IN_W-1:0] acc_prod;
    logic                     acc_v;

    // Accumulate stage
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [c_cnt_w-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]         f_q, f_d;
    logic                     vo_q, vo_d;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;

    // Capture operands on accepted input; clear drops the pair in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
        end else if (clear) begin
            v1_q <= 1'b0;
        end else if (valid_in) begin
            a_q  <= a;
            b_q  <= b;
            v1_q <= 1'b1;
        end else begin
            v1_q <= 1'b0;
        end
    end

    // Operands are sign-extended first so the product is never truncated.
    assign mult = (2*IN_W)'(a_q) * (2*IN_W)'(b_q);

    generate
        if (PIPE_MULT != 0) begin : g_pipe_mult
            logic signed [2*IN_W-1:0] p_q;
            logic                     v2_q;

            // Optional product register stage between multiplier and adder.
            always_ff @(posedge clk) begin
                if (reset) begin
                    p_q  <= '0;
                    v2_q <= 1'b0;
                end else begin
                    if (v1_q) begin
                        p_q <= mult;
                    end
                    v2_q <= v1_q && !clear;
                end
            end

            assign acc_prod = p_q;
            assign acc_v    = v2_q;
        end else begin : g_comb_mult
            assign acc_prod = mult;
            assign acc_v    = v1_q;
        end
    endgenerate

    // Element 0 ignores the stale accumulator, so no explicit clear is needed.
    assign acc_base = (cnt_q == '0) ? '0 : acc_q;
    assign prod_ext = ACC_W'(acc_prod);

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  clamp_now;
    logic                  sticky_base;
    logic                  sticky_q, sticky_d;
    logic                  sat_q, sat_d;

    // One guard bit detects overflow; the top two bits disagree on overflow.
    assign sum_wide    = (ACC_W+1)'(acc_base) + (ACC_W+1)'(prod_ext);
    assign clamp_now   = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    assign sum         = clamp_now ? (sum_wide[ACC_W] ? c_acc_min : c_acc_max)
                                   : sum_wide[ACC_W-1:0];
    assign sticky_base = (cnt_q == '0) ? 1'b0 : sticky_q;
    assign sat         = sat_q;
`else
    assign sum = acc_base + prod_ext;
    assign sat = 1'b0;
`endif

    // Next-state for accumulator, counter and result; clear aborts partial work.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        f_d   = f_q;
        vo_d  = 1'b0;
`ifdef MAC_SAT_EN
        sticky_d = sticky_q;
        sat_d    = sat_q;
`endif
        if (acc_v) begin
            if (cnt_q == c_cnt_last) begin
                f_d   = sum;
                vo_d  = 1'b1;
                cnt_d = '0;
`ifdef MAC_SAT_EN
                sat_d    = sticky_base | clamp_now;
                sticky_d = 1'b0;
`endif
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + c_cnt_w'(1);
`ifdef MAC_SAT_EN
                sticky_d = sticky_base | clamp_now;
`endif
            end
        end
        // A last-element result above is still emitted; only the count is reset.
        if (clear) begin
            cnt_d = '0;
`ifdef MAC_SAT_EN
            sticky_d = 1'b0;
`endif
        end
    end

    // Accumulate-stage state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            f_q   <= '0;
            vo_q  <= 1'b0;
`ifdef MAC_SAT_EN
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            f_q   <= f_d;
            vo_q  <= vo_d;
`ifdef MAC_SAT_EN
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
`endif
        end
    end

    assign f         = f_q;
    assign valid_out = vo_q;

endmodule
`default_nettype wire

// File: tb/tb_part2_dot_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_part2_dot_mac
//  Purpose  : Directed bench for part2_dot_mac. Three instances share inputs:
//             defaults, PIPE_MULT=1, and ACC_W=16 (wrap or clamp per
//             MAC_SAT_EN). A per-cycle vector table covers the streaming
//             cases; hand-written sequences cover reset and clear corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_part2_dot_mac;

`ifdef MAC_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_in, clear;
    logic [7:0]  a, b;
    logic [19:0] f_a, f_b;
    logic [15:0] f_c;
    logic        vo_a, vo_b, vo_c, sat_a, sat_b, sat_c;

    part2_dot_mac dut_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear(clear),
        .a(a), .b(b), .f(f_a), .valid_out(vo_a), .sat(sat_a)
    );

    part2_dot_mac #(.PIPE_MULT(1)) dut_b (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear(clear),
        .a(a), .b(b), .f(f_b), .valid_out(vo_b), .sat(sat_b)
    );

    part2_dot_mac #(.ACC_W(16)) dut_c (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear(clear),
        .a(a), .b(b), .f(f_c), .valid_out(vo_c), .sat(sat_c)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic signed [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One row per clock edge: inputs presented at that edge, outputs expected after it.
    typedef struct {
        logic       vi;
        logic       clr;
        logic [7:0] a;
        logic [7:0] b;
        logic       vo_a;
        int         f_a;
        logic       vo_b;
        int         f_b;
        int         f_c;
        logic       s_c;
    } row_t;

    localparam int NR = 41;
    row_t tv[NR];

    task automatic put(input int r, input int av, input int bv);
        tv[r].vi = 1'b1;
        tv[r].a  = 8'(av);
        tv[r].b  = 8'(bv);
    endtask

    // Result events: row where dut_a/dut_c pulse (dut_b pulses one row later).
    int ev_row[6] = '{4, 8, 20, 29, 34, 38};
    int ev_f[6]   = '{-72, 65536, 100, 4, 64516, 4};
    int ev_cw[6]  = '{-72, 0, 100, 4, -1020, 4};
    int ev_cs[6]  = '{-72, 32767, 100, 4, 32767, 4};
    bit ev_s[6]   = '{0, 1, 0, 0, 1, 0};

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int ca, cb, cc;
        logic cs;
        int na, nb, nc, ta, tb, fa_p, fb_p, fc_p;

        // ---------------- build the vector table ----------------
        for (int r = 0; r < NR; r++) begin
            tv[r].vi = 1'b0; tv[r].clr = 1'b0; tv[r].a = '0; tv[r].b = '0;
        end
        // back-to-back: (1,2),(3,4),(-5,6),(7,-8) then (-128,-128)x4
        put(0, 1, 2); put(1, 3, 4); put(2, -5, 6); put(3, 7, -8);
        for (int r = 4; r < 8; r++) put(r, -128, -128);
        // gapped vector over 9 cycles: 100 - 15 + 16 - 1 = 100
        put(11, 10, 10); put(13, -3, 5); put(16, 4, 4); put(19, 1, -1);
        // two pairs, then clear with a discarded pair, then (1,1)x4
        put(22, 5, 5); put(23, 6, 6); put(24, 9, 9); tv[24].clr = 1'b1;
        for (int r = 25; r < 29; r++) put(r, 1, 1);
        // (127,127)x4 then (1,1)x4 back-to-back
        for (int r = 30; r < 34; r++) put(r, 127, 127);
        for (int r = 34; r < 38; r++) put(r, 1, 1);

        ca = 0; cb = 0; cc = 0; cs = 1'b0;
        for (int r = 0; r < NR; r++) begin
            tv[r].vo_a = 1'b0;
            tv[r].vo_b = 1'b0;
            for (int e = 0; e < 6; e++) begin
                if (ev_row[e] == r) begin
                    tv[r].vo_a = 1'b1;
                    ca = ev_f[e];
                    cc = c_sat_en ? ev_cs[e] : ev_cw[e];
                    cs = c_sat_en && ev_s[e];
                end
                if (ev_row[e] + 1 == r) begin
                    tv[r].vo_b = 1'b1;
                    cb = ev_f[e];
                end
            end
            tv[r].f_a = ca;
            tv[r].f_b = cb;
            tv[r].f_c = cc;
            tv[r].s_c = cs;
        end

        // ---------------- reset state ----------------
        reset = 1'b1; valid_in = 1'b0; clear = 1'b0; a = '0; b = '0;
        step(); step();
        chk("reset f_a", $signed(f_a), 0);
        chk("reset vo_a", vo_a, 0);
        chk("reset sat_a", sat_a, 0);
        chk("reset f_b", $signed(f_b), 0);
        chk("reset vo_b", vo_b, 0);
        chk("reset f_c", $signed(f_c), 0);
        chk("reset vo_c", vo_c, 0);
        chk("reset sat_c", sat_c, 0);
        reset = 1'b0;

        // ---------------- table-driven streaming ----------------
        for (int r = 0; r < NR; r++) begin
            valid_in = tv[r].vi;
            clear    = tv[r].clr;
            a        = tv[r].a;
            b        = tv[r].b;
            step();
            chk($sformatf("r%0d vo_a", r), vo_a, int'(tv[r].vo_a));
            chk($sformatf("r%0d f_a", r), $signed(f_a), tv[r].f_a);
            chk($sformatf("r%0d vo_b", r), vo_b, int'(tv[r].vo_b));
            chk($sformatf("r%0d f_b", r), $signed(f_b), tv[r].f_b);
            chk($sformatf("r%0d vo_c", r), vo_c, int'(tv[r].vo_a));
            chk($sformatf("r%0d f_c", r), $signed(f_c), tv[r].f_c);
            chk($sformatf("r%0d sat_c", r), sat_c, int'(tv[r].s_c));
            chk($sformatf("r%0d sat_a", r), sat_a, 0);
        end
        valid_in = 1'b0; clear = 1'b0;

        // ---------------- reset mid-vector, then (2,3)x4 ----------------
        a = 8'd2; b = 8'd3; valid_in = 1'b1;
        step(); step(); step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midreset f_a", $signed(f_a), 0);
            chk("midreset vo_a", vo_a, 0);
            chk("midreset f_b", $signed(f_b), 0);
            chk("midreset vo_b", vo_b, 0);
            chk("midreset f_c", $signed(f_c), 0);
            chk("midreset sat_c", sat_c, 0);
        end
        reset = 1'b0;
        na = 0; nb = 0; nc = 0; ta = -1; tb = -1; fa_p = 0; fb_p = 0; fc_p = 0;
        for (int i = 0; i < 10; i++) begin
            valid_in = (i < 4);
            step();
            if (vo_a) begin na++; if (ta < 0) ta = i; fa_p = $signed(f_a); end
            if (vo_b) begin nb++; if (tb < 0) tb = i; fb_p = $signed(f_b); end
            if (vo_c) begin nc++; fc_p = $signed(f_c); end
        end
        chk("postreset pulses_a", na, 1);
        chk("postreset latency_a", ta, 4);
        chk("postreset f_a", fa_p, 24);
        chk("postreset pulses_b", nb, 1);
        chk("postreset latency_b", tb, 5);
        chk("postreset f_b", fb_p, 24);
        chk("postreset pulses_c", nc, 1);
        chk("postreset f_c", fc_p, 24);

        // ---------------- clear coinciding with last accumulate ----------------
        a = 8'd2; b = 8'd2;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0; clear = 1'b1;
        step();
        chk("clrlast vo_a", vo_a, 1);
        chk("clrlast f_a", $signed(f_a), 16);
        chk("clrlast vo_c", vo_c, 1);
        chk("clrlast f_c", $signed(f_c), 16);
        chk("clrlast vo_b", vo_b, 0);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clrlast after vo_b", vo_b, 0);
            chk("clrlast after f_b", $signed(f_b), 24);
            chk("clrlast after vo_a", vo_a, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
